caliptra_apb_initiator: RTL and testbench



---
 rtl/caliptra_apb_initiator_if.sv | 52 +++++
 rtl/caliptra_apb_initiator.sv | 127 ++++++++++++
 tb/tb_caliptra_apb_initiator.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/caliptra_apb_initiator_if.sv
// Command, response and APB signal bundle for caliptra_apb_initiator.
// Latency: none, this file only declares wires.
// Backpressure: cmd_ready/rsp_ready handshakes; pready stretches the APB access phase.
interface caliptra_apb_initiator_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int USER_W = 32
);
  // Command channel
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [USER_W-1:0] cmd_pauser;
  // Response channel
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  // APB requester side
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [USER_W-1:0] pauser;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  // master: the initiator block itself
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_pauser,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  rsp_ready,
    output psel, penable, pwrite, paddr, pwdata, pauser,
    input  prdata, pready, pslverr
  );

  // slave: the command source, response sink and APB responder around it
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_pauser,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output rsp_ready,
    input  psel, penable, pwrite, paddr, pwdata, pauser,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/caliptra_apb_initiator.sv
// Hardware APB requester: one single-beat APB transfer per command, response returned on rsp channel.
// Latency: cmd accept at T -> rsp_valid at T+3 with zero wait states (T+1 for a misaligned command).
// Backpressure: cmd_ready low while busy; response held until rsp_ready; optional macro
// CALIPTRA_APB_INIT_TIMEOUT_EN aborts an ACCESS phase after TIMEOUT_CYCLES cycles.
module caliptra_apb_initiator #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int USER_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic                     clk,
  input logic                     rst_b,
  caliptra_apb_initiator_if.master bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state;

`ifdef CALIPTRA_APB_INIT_TIMEOUT_EN
  localparam int RAW_W = $clog2(TIMEOUT_CYCLES);
  localparam int CNT_W = (RAW_W < 8) ? 8 : ((RAW_W > 32) ? 32 : RAW_W);
  logic [CNT_W-1:0] to_cnt;
  logic             to_hit;
  logic             rsp_timeout_q;

  // Limit is reached on the TIMEOUT_CYCLES-th ACCESS cycle without pready
  assign to_hit          = (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign bus.rsp_timeout = rsp_timeout_q;
`else
  assign bus.rsp_timeout = 1'b0;
`endif

  // Single FSM: every output is a register updated on state transitions
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state         <= IDLE;
      bus.cmd_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      bus.psel      <= 1'b0;
      bus.penable   <= 1'b0;
      bus.pwrite    <= 1'b0;
      bus.paddr     <= '0;
      bus.pwdata    <= '0;
      bus.pauser    <= '0;
`ifdef CALIPTRA_APB_INIT_TIMEOUT_EN
      to_cnt        <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // cmd_ready rises one cycle after entering IDLE, giving the 5-cycle issue interval
          bus.cmd_ready <= 1'b1;
          if (bus.cmd_valid && bus.cmd_ready) begin
            bus.cmd_ready <= 1'b0;
            if (bus.cmd_addr[1:0] != 2'b00) begin
              // Misaligned: answer immediately, APB stays untouched
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_rdata <= '0;
`ifdef CALIPTRA_APB_INIT_TIMEOUT_EN
              rsp_timeout_q <= 1'b0;
`endif
              state <= RESP;
            end else begin
              bus.psel   <= 1'b1;
              bus.pwrite <= bus.cmd_write;
              bus.paddr  <= bus.cmd_addr;
              bus.pwdata <= bus.cmd_wdata;
              bus.pauser <= bus.cmd_pauser;
              state      <= SETUP;
            end
          end
        end

        SETUP: begin
          // pready is not looked at here; ACCESS always follows
          bus.penable <= 1'b1;
`ifdef CALIPTRA_APB_INIT_TIMEOUT_EN
          to_cnt <= '0;
`endif
          state <= ACCESS;
        end

        ACCESS: begin
          if (bus.pready) begin
            bus.psel      <= 1'b0;
            bus.penable   <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= bus.pslverr;
            bus.rsp_rdata <= (!bus.pwrite && !bus.pslverr) ? bus.prdata : '0;
`ifdef CALIPTRA_APB_INIT_TIMEOUT_EN
            rsp_timeout_q <= 1'b0;
`endif
            state <= RESP;
          end
`ifdef CALIPTRA_APB_INIT_TIMEOUT_EN
          else if (to_hit) begin
            bus.psel      <= 1'b0;
            bus.penable   <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b1;
            bus.rsp_rdata <= '0;
            rsp_timeout_q <= 1'b1;
            state         <= RESP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end

        RESP: begin
          // Response fields are only written on entry, so they stay stable here
          if (bus.rsp_valid && bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_caliptra_apb_initiator.sv
// Directed bench for caliptra_apb_initiator: inputs driven and outputs sampled on the falling edge.
// Latency: cycle-exact checks against hand-computed timing relative to the command handshake.
// Backpressure: exercises pready wait states, held rsp_ready, timeout (when the macro is set) and reset.
module tb_caliptra_apb_initiator;

  logic clk;
  logic rst_b;
  int   tests;
  int   fails;

  caliptra_apb_initiator_if #(.ADDR_W(32), .DATA_W(32), .USER_W(32)) bus ();

  caliptra_apb_initiator #(
    .ADDR_W(32), .DATA_W(32), .USER_W(32), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk  (clk),
    .rst_b(rst_b),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Waits (bounded) for cmd_ready at a falling edge, presents one command for one cycle.
  // Returns at the falling edge of cycle T+1.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] u);
    int n;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_wait", 64'(bus.cmd_ready), 64'd1);
    bus.cmd_write  = w;
    bus.cmd_addr   = a;
    bus.cmd_wdata  = d;
    bus.cmd_pauser = u;
    bus.cmd_valid  = 1'b1;
    @(negedge clk);
    bus.cmd_valid  = 1'b0;
  endtask

  initial begin
    logic [31:0] held;
    int          n;
    tests = 0;
    fails = 0;
    rst_b          = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_write  = 1'b0;
    bus.cmd_addr   = '0;
    bus.cmd_wdata  = '0;
    bus.cmd_pauser = '0;
    bus.rsp_ready  = 1'b1;
    bus.prdata     = '0;
    bus.pready     = 1'b0;
    bus.pslverr    = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_psel",      64'(bus.psel),        64'd0);
    chk("rst_penable",   64'(bus.penable),     64'd0);
    chk("rst_cmd_ready", 64'(bus.cmd_ready),   64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid),   64'd0);
    chk("rst_paddr",     64'(bus.paddr),       64'd0);
    chk("rst_pwdata",    64'(bus.pwdata),      64'd0);
    chk("rst_pauser",    64'(bus.pauser),      64'd0);
    chk("rst_rsp_flds",  {bus.rsp_rdata, 30'd0, bus.rsp_err, bus.rsp_timeout}, 64'd0);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);

    // 1: write with two wait states
    issue(1'b1, 32'h3002_0000, 32'hDEAD_BEEF, 32'h0000_00A5);
    chk("t1_setup_psel",    64'(bus.psel),    64'd1);
    chk("t1_setup_penable", 64'(bus.penable), 64'd0);
    chk("t1_paddr",         64'(bus.paddr),   64'h3002_0000);
    chk("t1_pwdata",        64'(bus.pwdata),  64'hDEAD_BEEF);
    chk("t1_pwrite",        64'(bus.pwrite),  64'd1);
    chk("t1_cmd_ready_low", 64'(bus.cmd_ready), 64'd0);
    @(negedge clk);  // T+2
    chk("t1_acc0", {62'd0, bus.psel, bus.penable}, 64'd3);
    @(negedge clk);  // T+3
    chk("t1_acc1", {62'd0, bus.psel, bus.penable}, 64'd3);
    @(negedge clk);  // T+4
    chk("t1_acc2", {62'd0, bus.psel, bus.penable}, 64'd3);
    chk("t1_no_rsp_yet", 64'(bus.rsp_valid), 64'd0);
    bus.pready = 1'b1;
    @(negedge clk);  // T+5
    bus.pready = 1'b0;
    chk("t1_done_apb", {62'd0, bus.psel, bus.penable}, 64'd0);
    chk("t1_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("t1_rsp_err",   64'(bus.rsp_err),   64'd0);
    chk("t1_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    @(negedge clk);  // T+6
    chk("t1_rsp_drop",   64'(bus.rsp_valid), 64'd0);
    chk("t1_pwdata_kept", 64'(bus.pwdata),   64'hDEAD_BEEF);
    chk("t1_ready_gap",  64'(bus.cmd_ready), 64'd0);
    @(negedge clk);  // T+7
    chk("t1_ready_back", 64'(bus.cmd_ready), 64'd1);

    // 2: zero-wait read, pready already high during SETUP
    bus.prdata = 32'h1234_5678;
    issue(1'b0, 32'h3003_0004, 32'h0, 32'hCAFE_0001);
    bus.pready = 1'b1;
    chk("t2_setup", {62'd0, bus.psel, bus.penable}, 64'd2);
    chk("t2_pauser_setup", 64'(bus.pauser), 64'hCAFE_0001);
    chk("t2_pwrite", 64'(bus.pwrite), 64'd0);
    @(negedge clk);  // T+2
    chk("t2_access", {62'd0, bus.psel, bus.penable}, 64'd3);
    chk("t2_pauser_access", 64'(bus.pauser), 64'hCAFE_0001);
    chk("t2_no_rsp_yet", 64'(bus.rsp_valid), 64'd0);
    @(negedge clk);  // T+3
    bus.pready = 1'b0;
    chk("t2_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("t2_rsp_rdata", 64'(bus.rsp_rdata), 64'h1234_5678);
    chk("t2_rsp_err",   64'(bus.rsp_err),   64'd0);
    chk("t2_idle_psel", 64'(bus.psel),      64'd0);
    @(negedge clk);

    // 3a: read completing with pslverr
    bus.prdata = 32'hFFFF_FFFF;
    issue(1'b0, 32'h3003_0008, 32'h0, 32'h0000_0002);
    @(negedge clk);  // T+2
    bus.pready  = 1'b1;
    bus.pslverr = 1'b1;
    @(negedge clk);  // T+3
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    chk("t3_rsp_valid",   64'(bus.rsp_valid),   64'd1);
    chk("t3_rsp_err",     64'(bus.rsp_err),     64'd1);
    chk("t3_rsp_timeout", 64'(bus.rsp_timeout), 64'd0);
    chk("t3_rsp_rdata",   64'(bus.rsp_rdata),   64'd0);
    @(negedge clk);

    // 3b: misaligned address, no APB activity
    issue(1'b0, 32'h3000_0002, 32'h0, 32'h0000_0003);
    chk("t3m_no_psel",   64'(bus.psel),      64'd0);
    chk("t3m_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("t3m_rsp_err",   64'(bus.rsp_err),   64'd1);
    chk("t3m_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    @(negedge clk);

    // 4: response held off for 10 cycles
    bus.rsp_ready = 1'b0;
    bus.prdata    = 32'hA5A5_0F0F;
    issue(1'b0, 32'h3003_000C, 32'h0, 32'h0000_0004);
    bus.pready = 1'b1;
    @(negedge clk);  // T+2
    @(negedge clk);  // T+3
    bus.pready = 1'b0;
    bus.prdata = 32'h0;
    held = 32'hA5A5_0F0F;
    for (int i = 0; i < 10; i++) begin
      chk("t4_hold_valid", 64'(bus.rsp_valid), 64'd1);
      chk("t4_hold_rdata", 64'(bus.rsp_rdata), 64'(held));
      chk("t4_hold_ready", 64'(bus.cmd_ready), 64'd0);
      @(negedge clk);
    end
    chk("t4_hold_err", 64'(bus.rsp_err), 64'd0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("t4_rel_valid", 64'(bus.rsp_valid), 64'd0);
    chk("t4_rel_ready", 64'(bus.cmd_ready), 64'd0);
    @(negedge clk);
    chk("t4_ready_back", 64'(bus.cmd_ready), 64'd1);

    // 5: pready never arrives
    issue(1'b1, 32'h3002_0010, 32'h0BAD_F00D, 32'h0000_0005);
`ifdef CALIPTRA_APB_INIT_TIMEOUT_EN
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.penable !== 1'b1) break;
      n++;
    end
    chk("t5_penable_cycles", 64'(n),               64'd8);
    chk("t5_rsp_valid",      64'(bus.rsp_valid),   64'd1);
    chk("t5_rsp_err",        64'(bus.rsp_err),     64'd1);
    chk("t5_rsp_timeout",    64'(bus.rsp_timeout), 64'd1);
    chk("t5_rsp_rdata",      64'(bus.rsp_rdata),   64'd0);
    chk("t5_psel_off",       64'(bus.psel),        64'd0);
    @(negedge clk);
    // enter a fresh ACCESS phase for the reset test
    issue(1'b1, 32'h3002_0014, 32'h1111_2222, 32'h0000_0006);
    @(negedge clk);
    @(negedge clk);
`else
    n = 0;
    repeat (1000) @(negedge clk);
    chk("t5_still_access", {62'd0, bus.psel, bus.penable}, 64'd3);
    chk("t5_no_rsp",       64'(bus.rsp_valid),   64'd0);
    chk("t5_timeout_tied", 64'(bus.rsp_timeout), 64'd0);
`endif

    // 6: asynchronous reset in the middle of ACCESS
    chk("t6_pre_access", {62'd0, bus.psel, bus.penable}, 64'd3);
    rst_b = 1'b0;
    #1;
    chk("t6_rst_apb",       {62'd0, bus.psel, bus.penable}, 64'd0);
    chk("t6_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    @(negedge clk);
    chk("t6_rst_no_rsp", 64'(bus.rsp_valid), 64'd0);
    rst_b = 1'b1;
    @(negedge clk);
    chk("t6_ready_after", 64'(bus.cmd_ready), 64'd1);
    issue(1'b1, 32'h3002_0020, 32'h5555_AAAA, 32'h0000_0007);
    bus.pready = 1'b1;
    chk("t6_setup", {62'd0, bus.psel, bus.penable}, 64'd2);
    chk("t6_pwdata", 64'(bus.pwdata), 64'h5555_AAAA);
    @(negedge clk);  // T+2
    @(negedge clk);  // T+3
    bus.pready = 1'b0;
    chk("t6_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("t6_rsp_err",   64'(bus.rsp_err),   64'd0);
    chk("t6_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    @(negedge clk);
    chk("t6_rsp_drop",  64'(bus.rsp_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
